// File: rtl/rv_imm_pkg.sv
// Shared RV32 immediate-type codes, instruction constants and range-check helper
// used by the immediate generator and the instruction encoder.
package rv_imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_U   = 3'b011,
      IMM_J   = 3'b100,
      IMM_CSR = 3'b101
   } imm_type_e;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   localparam logic [6:0]  OPC_OP_IMM = 7'h13;
   localparam logic [6:0]  OPC_STORE  = 7'h23;
   localparam logic [6:0]  OPC_LUI    = 7'h37;
   localparam logic [6:0]  OPC_BRANCH = 7'h63;
   localparam logic [6:0]  OPC_JAL    = 7'h6F;
   localparam logic [6:0]  OPC_SYSTEM = 7'h73;

   // True when imm[31:lo] are all equal, i.e. the value fits a signed field of lo+1 bits.
   function automatic logic upper_is_sext(input logic [31:0] imm, input logic [4:0] lo);
      logic [31:0] sh_s;
      sh_s = 32'($signed(imm) >>> lo);
      return (sh_s == 32'h0000_0000) || (sh_s == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational range check and field packing of one RV32 instruction word.
// Illegal types or out-of-range immediates yield the NOP word with err set.
module instr_pack
   import rv_imm_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic [2:0]  imm_type,
   input  logic [31:0] imm,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] csr,
   output logic        err,
   output logic [31:0] word
);

   logic        err_s;
   logic [31:0] packed_s;

   // Legality check and bit scatter per immediate type.
   always_comb begin
      err_s    = 1'b1;
      packed_s = 32'h0000_0000;
      case (imm_type)
         IMM_I: begin
            err_s    = !upper_is_sext(imm, 5'd11);
            packed_s = {imm[11:0], rs1, funct3, rd, opcode};
         end
         IMM_S: begin
            err_s    = !upper_is_sext(imm, 5'd11);
            packed_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         end
         IMM_B: begin
            err_s    = !upper_is_sext(imm, 5'd12) || imm[0];
            packed_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         end
         IMM_U: begin
            err_s    = (imm[11:0] != 12'h000);
            packed_s = {imm[31:12], rd, opcode};
         end
         IMM_J: begin
            err_s    = !upper_is_sext(imm, 5'd20) || imm[0];
            packed_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         end
         IMM_CSR: begin
            err_s    = (imm[31:5] != 27'h000_0000);
            packed_s = {csr, imm[4:0], funct3, rd, opcode};
         end
         default: begin
            err_s    = 1'b1;
            packed_s = 32'h0000_0000;
         end
      endcase
   end

   assign err  = err_s;
   assign word = err_s ? NOP : packed_s;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder: stage 1 holds the packed word,
// stage 2 is the output register; saturating counters track good/bad words.
module instr_encoder
   import rv_imm_pkg::*;
#(
   parameter int          CNT_W = 16,
   parameter logic [31:0] NOP   = NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_imm_type,
   input  logic [31:0]      in_imm,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [11:0]      in_csr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_ok,
   output logic [CNT_W-1:0] cnt_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic        s1_v_r;
   logic [31:0] s1_word_r;
   logic        s1_err_r;
   logic        pack_err_s;
   logic [31:0] pack_word_s;
   logic        in_fire_s;
   logic        out_fire_s;
   logic        s2_load_s;

   instr_pack #(.NOP(NOP)) u_pack (
      .imm_type (in_imm_type),
      .imm      (in_imm),
      .opcode   (in_opcode),
      .rd       (in_rd),
      .funct3   (in_funct3),
      .rs1      (in_rs1),
      .rs2      (in_rs2),
      .csr      (in_csr),
      .err      (pack_err_s),
      .word     (pack_word_s)
   );

   assign in_ready   = !s1_v_r || !out_valid || out_ready;
   assign in_fire_s  = in_valid && in_ready;
   assign out_fire_s = out_valid && out_ready;
   assign s2_load_s  = s1_v_r && (!out_valid || out_ready);

   // Stage 1: capture the packed word; empties when it moves to stage 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_r    <= 1'b0;
         s1_word_r <= 32'h0000_0000;
         s1_err_r  <= 1'b0;
      end else if (in_fire_s) begin
         s1_v_r    <= 1'b1;
         s1_word_r <= pack_word_s;
         s1_err_r  <= pack_err_s;
      end else if (s2_load_s) begin
         s1_v_r    <= 1'b0;
      end
   end

   // Stage 2: output register, held stable until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= 32'h0000_0000;
         out_err   <= 1'b0;
      end else if (s2_load_s) begin
         out_valid <= 1'b1;
         out_instr <= s1_word_r;
         out_err   <= s1_err_r;
      end else if (out_fire_s) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating good/bad counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_ok  <= CNT_ZERO;
         cnt_err <= CNT_ZERO;
      end else if (cnt_clr) begin
         cnt_ok  <= CNT_ZERO;
         cnt_err <= CNT_ZERO;
      end else if (out_fire_s) begin
         if (out_err) begin
            if (cnt_err != CNT_MAX) begin
               cnt_err <= cnt_err + CNT_ONE;
            end
         end else begin
            if (cnt_ok != CNT_MAX) begin
               cnt_ok <= cnt_ok + CNT_ONE;
            end
         end
      end
   end

endmodule
